// File: rtl/simd_mem_arbiter.sv
// simd_mem_arbiter
// Round-robin burst arbiter that shares the single-port operand RAM between
// the host operand loader (0, write), the core read engine (1, read) and the
// result writeback (2, write). A winner owns the RAM for 1..16 consecutive
// beats. A one-cycle IDLE gap always separates two bursts.
module simd_mem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    input  logic [LEN_W-1:0]  len2,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata2,
    output logic [2:0]        gnt,
    output logic [2:0]        beat_ack,
    output logic [2:0]        done,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid1,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [1:0]        ptr, ptr_n;
    logic [1:0]        winner, winner_n;
    logic [ADDR_W-1:0] base, base_n;
    logic [LEN_W-1:0]  last, last_n;
    logic [LEN_W-1:0]  cnt, cnt_n;
    logic              rvalid1_q;

    logic [1:0]        cand1, cand2, pick;
    logic              pick_valid;
    logic [2:0]        win_oh;
    logic              last_beat;

    // Request bit lookup by requester index; index 3 never requests.
    function automatic logic has_req(input logic [2:0] r, input logic [1:0] i);
        case (i)
            2'd0:    has_req = r[0];
            2'd1:    has_req = r[1];
            2'd2:    has_req = r[2];
            default: has_req = 1'b0;
        endcase
    endfunction

    // Round-robin search order ptr, ptr+1, ptr+2 (mod 3) and winner pick.
    always_comb begin
        cand1      = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
        cand2      = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;
        pick       = 2'd0;
        pick_valid = 1'b0;
        if (has_req(req, ptr)) begin
            pick       = ptr;
            pick_valid = 1'b1;
        end else if (has_req(req, cand1)) begin
            pick       = cand1;
            pick_valid = 1'b1;
        end else if (has_req(req, cand2)) begin
            pick       = cand2;
            pick_valid = 1'b1;
        end
    end

    assign last_beat = (cnt == last);

    // Next-state logic: latch the winner's burst in IDLE, count beats in BURST.
    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        winner_n = winner;
        base_n   = base;
        last_n   = last;
        cnt_n    = cnt;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    winner_n = pick;
                    cnt_n    = '0;
                    state_n  = BURST;
                    case (pick)
                        2'd0: begin
                            base_n = addr0;
                            last_n = len0;
                        end
                        2'd1: begin
                            base_n = addr1;
                            last_n = len1;
                        end
                        default: begin
                            base_n = addr2;
                            last_n = len2;
                        end
                    endcase
                end
            end
            BURST: begin
                if (last_beat) begin
                    state_n = IDLE;
                    ptr_n   = (winner == 2'd2) ? 2'd0 : winner + 2'd1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, burst bookkeeping and the one-cycle read-valid delay.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            winner    <= 2'd0;
            base      <= '0;
            last      <= '0;
            cnt       <= '0;
            rvalid1_q <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            winner    <= winner_n;
            base      <= base_n;
            last      <= last_n;
            cnt       <= cnt_n;
            rvalid1_q <= beat_ack[1];
        end
    end

    // RAM-side and handshake outputs decoded from the registered burst state.
    always_comb begin
        win_oh    = 3'b000;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (state == BURST) begin
            win_oh   = 3'(3'b001 << winner);
            mem_addr = base + ADDR_W'(cnt);
            mem_we   = (winner != 2'd1);
            if (winner == 2'd0) begin
                mem_wdata = wdata0;
            end else if (winner == 2'd2) begin
                mem_wdata = wdata2;
            end
        end
    end

    assign busy     = (state == BURST);
    assign gnt      = win_oh;
    assign beat_ack = win_oh;
    assign done     = last_beat ? win_oh : 3'b000;
    assign rvalid1  = rvalid1_q;
    assign rdata1   = mem_rdata;

endmodule

// File: tb/tb_simd_mem_arbiter.sv
// tb_simd_mem_arbiter
// Directed stimulus for the RAM arbiter with a queue-based scoreboard. The
// stimulus thread pushes the beats and read returns it expects, tagged with
// the cycle they must appear in; a negedge monitor pops and compares them.
module tb_simd_mem_arbiter;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 64;
    localparam int LEN_W  = 4;

    logic              clk;
    logic              reset;
    logic [2:0]        req;
    logic [ADDR_W-1:0] addr0, addr1, addr2;
    logic [LEN_W-1:0]  len0, len1, len2;
    logic [DATA_W-1:0] wdata0, wdata2;
    logic [2:0]        gnt, beat_ack, done;
    logic [DATA_W-1:0] rdata1;
    logic              rvalid1, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    simd_mem_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .addr0    (addr0),
        .addr1    (addr1),
        .addr2    (addr2),
        .len0     (len0),
        .len1     (len1),
        .len2     (len2),
        .wdata0   (wdata0),
        .wdata2   (wdata2),
        .gnt      (gnt),
        .beat_ack (beat_ack),
        .done     (done),
        .rdata1   (rdata1),
        .rvalid1  (rvalid1),
        .busy     (busy),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        int          cyc;
        logic [2:0]  ack;
        logic [5:0]  addr;
        logic        we;
        logic [63:0] wdata;
        logic [2:0]  done;
    } beat_t;

    typedef struct {
        int          cyc;
        logic [63:0] data;
    } rd_t;

    beat_t beat_q[$];
    rd_t   rd_q[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [63:0] ram [64];
    logic [63:0] wbase0, wbase2;
    int          w0_cnt, w2_cnt;

    function automatic logic [63:0] pre(input int i);
        return {32'hC0DE0000 + 32'(i), 32'h5A5A0000 + 32'(i)};
    endfunction

    function automatic logic [63:0] out_vec();
        return 64'({gnt, beat_ack, done, rvalid1, busy, mem_we, mem_addr});
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) tick();
    endtask

    // Expected beats of a burst whose request is sampled at the edge ending cycle n.
    task automatic push_burst(input int r, input int base, input int len, input int n,
                              input logic [63:0] wstart, input int nbeats);
        beat_t b;
        rd_t   rd;
        for (int k = 0; k < nbeats; k++) begin
            b.cyc   = n + 1 + k;
            b.ack   = 3'(1 << r);
            b.addr  = 6'((base + k) % 64);
            b.we    = (r != 1);
            b.wdata = (r == 1) ? 64'h0 : wstart + 64'(k);
            b.done  = (k == len) ? b.ack : 3'b000;
            beat_q.push_back(b);
            if (r == 1) begin
                rd.cyc  = n + 2 + k;
                rd.data = pre((base + k) % 64);
                rd_q.push_back(rd);
            end
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] r);
        req = r;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Synchronous RAM model, one-cycle read latency
    initial begin
        for (int i = 0; i < 64; i++) ram[i] = pre(i);
        mem_rdata = '0;
        forever begin
            logic [63:0] rd_word;
            @(posedge clk);
            rd_word = ram[mem_addr];
            if (mem_we) ram[mem_addr] = mem_wdata;
            mem_rdata <= rd_word;
        end
    end

    // Write requesters step to their next word on the cycle after beat_ack
    initial begin
        logic p0, p2;
        forever begin
            @(negedge clk);
            p0 = beat_ack[0];
            p2 = beat_ack[2];
            @(posedge clk);
            #2;
            if (p0) w0_cnt++;
            if (p2) w2_cnt++;
            wdata0 = wbase0 + 64'(w0_cnt);
            wdata2 = wbase2 + 64'(w2_cnt);
        end
    end

    // Monitor: invariants each cycle, pop the scoreboard on beats and read returns
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                check_output("onehot_invariants",
                    64'({(gnt & (gnt - 3'd1)) != 3'd0,
                         (beat_ack & (beat_ack - 3'd1)) != 3'd0,
                         (done & (done - 3'd1)) != 3'd0,
                         (done & ~beat_ack) != 3'd0,
                         mem_we && (!busy || gnt[1])}), 64'h0);
                if (beat_ack != 3'b000) begin
                    if (beat_q.size() == 0) begin
                        check_output("unexpected_beat", 64'(beat_ack), 64'h0);
                    end else begin
                        beat_t e;
                        e = beat_q.pop_front();
                        check_output("beat_cycle", 64'(cyc), 64'(e.cyc));
                        check_output("beat_ack", 64'(beat_ack), 64'(e.ack));
                        check_output("beat_gnt", 64'(gnt), 64'(e.ack));
                        check_output("beat_addr", 64'(mem_addr), 64'(e.addr));
                        check_output("beat_we", 64'(mem_we), 64'(e.we));
                        check_output("beat_wdata", mem_wdata, e.wdata);
                        check_output("beat_done", 64'(done), 64'(e.done));
                    end
                end
                if (rvalid1) begin
                    if (rd_q.size() == 0) begin
                        check_output("unexpected_rvalid1", 64'(rvalid1), 64'h0);
                    end else begin
                        rd_t e;
                        e = rd_q.pop_front();
                        check_output("rvalid1_cycle", 64'(cyc), 64'(e.cyc));
                        check_output("rdata1", rdata1, e.data);
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends with a summary
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Directed stimulus sequence
    initial begin
        int n;
        reset  = 1'b0;
        req    = 3'b000;
        addr0  = '0;
        addr1  = '0;
        addr2  = '0;
        len0   = '0;
        len1   = '0;
        len2   = '0;
        wbase0 = 64'h0;
        wbase2 = 64'h0;
        w0_cnt = 0;
        w2_cnt = 0;
        wdata0 = '0;
        wdata2 = '0;

        // Reset state and quiet idle after release
        repeat (3) tick();
        check_output("reset_outputs", out_vec(), 64'h0);
        reset = 1'b1;
        repeat (3) tick();
        check_output("idle_after_reset", 64'({busy, mem_we, gnt}), 64'h0);

        // Single write burst, base 5, four beats
        $display("[TB] single write burst");
        n      = cyc;
        wbase0 = 64'hA0A0_A0A0_0000_00A0;
        w0_cnt = 0;
        addr0  = 6'd5;
        len0   = 4'd3;
        apply_stimulus(3'b001);
        push_burst(0, 5, 3, n, wbase0, 4);
        wait_cycle(n + 4);
        apply_stimulus(3'b000);
        wait_cycle(n + 5);
        check_output("write_gnt_cleared", 64'(gnt), 64'h0);
        check_output("write_busy_cleared", 64'(busy), 64'h0);
        for (int k = 0; k < 4; k++)
            check_output("ram_write", ram[5 + k], wbase0 + 64'(k));

        // Contention with all three requesting, single-beat bursts
        $display("[TB] contention");
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        n      = cyc;
        wbase0 = 64'h0A00_0000_0000_0000;
        wbase2 = 64'h2B00_0000_0000_0000;
        w0_cnt = 0;
        w2_cnt = 0;
        addr0  = 6'd10;
        addr1  = 6'd20;
        addr2  = 6'd30;
        len0   = 4'd0;
        len1   = 4'd0;
        len2   = 4'd0;
        apply_stimulus(3'b111);
        push_burst(0, 10, 0, n,     wbase0,       1);
        push_burst(1, 20, 0, n + 2, 64'h0,        1);
        push_burst(2, 30, 0, n + 4, wbase2,       1);
        push_burst(0, 10, 0, n + 6, wbase0 + 1,   1);
        wait_cycle(n + 7);
        apply_stimulus(3'b101);
        push_burst(2, 30, 0, n + 8, wbase2 + 1,   1);
        wait_cycle(n + 9);
        apply_stimulus(3'b000);
        wait_cycle(n + 11);

        // Request dropped after the first beat still completes the burst
        $display("[TB] request drop");
        n      = cyc;
        wbase0 = 64'hD00D_0000_0000_0000;
        w0_cnt = 0;
        addr0  = 6'd33;
        len0   = 4'd3;
        apply_stimulus(3'b001);
        push_burst(0, 33, 3, n, wbase0, 4);
        wait_cycle(n + 1);
        apply_stimulus(3'b000);
        wait_cycle(n + 6);

        // Wrapped read from base 62
        $display("[TB] wrapped read");
        n     = cyc;
        addr1 = 6'd62;
        len1  = 4'd3;
        apply_stimulus(3'b010);
        push_burst(1, 62, 3, n, 64'h0, 4);
        wait_cycle(n + 1);
        apply_stimulus(3'b000);
        wait_cycle(n + 6);

        // Reset during beat 3 of an eight-beat write abandons the burst
        $display("[TB] reset mid-burst");
        n      = cyc;
        wbase0 = 64'hBEEF_0000_0000_0000;
        w0_cnt = 0;
        addr0  = 6'd40;
        len0   = 4'd7;
        apply_stimulus(3'b001);
        push_burst(0, 40, 7, n, wbase0, 3);
        wait_cycle(n + 1);
        apply_stimulus(3'b000);
        wait_cycle(n + 4);
        reset = 1'b0;
        #1;
        check_output("async_reset_outputs", out_vec(), 64'h0);
        tick();
        tick();
        reset = 1'b1;
        n     = cyc;
        addr1 = 6'd50;
        addr2 = 6'd51;
        len1  = 4'd0;
        len2  = 4'd0;
        apply_stimulus(3'b110);
        push_burst(1, 50, 0, n, 64'h0, 1);
        wait_cycle(n + 1);
        apply_stimulus(3'b000);
        wait_cycle(n + 5);

        check_output("beat_queue_drained", 64'(beat_q.size()), 64'h0);
        check_output("read_queue_drained", 64'(rd_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
